// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with programmable almost-full/almost-empty thresholds, live count,
// sticky overflow/underflow flags and a build-time registered-read or FWFT output.
module sync_fifo_flex #(
  parameter int DSIZE     = 8,
  parameter int ASIZE     = 16,
  parameter int ABITS     = $clog2(ASIZE),
  parameter int AF_THRESH = ASIZE - 2,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             wr_en,
  input  logic [DSIZE-1:0] din,
  input  logic             rd_en,
  output logic [DSIZE-1:0] dout,
  input  logic             clr_err,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [ABITS:0]   count,
  output logic             overflow,
  output logic             underflow
);

  localparam int unsigned PW = ABITS + 1;
  localparam logic [ABITS:0] AF_T = PW'(AF_THRESH);
  localparam logic [ABITS:0] AE_T = PW'(AE_THRESH);

  logic [DSIZE-1:0] mem [ASIZE];
  logic [ABITS:0]   wr_ptr;
  logic [ABITS:0]   rd_ptr;
  logic [ABITS:0]   cnt;
  logic             rd_acc;
  logic             wr_acc;
  logic [ABITS-1:0] wr_idx;
  logic [ABITS-1:0] rd_idx;

  assign wr_idx = wr_ptr[ABITS-1:0];
  assign rd_idx = rd_ptr[ABITS-1:0];

  // Flags straight from the registered pointers and count
  assign empty        = (wr_ptr == rd_ptr);
  assign full         = (wr_idx == rd_idx) && (wr_ptr[ABITS] != rd_ptr[ABITS]);
  assign almost_full  = (cnt >= AF_T);
  assign almost_empty = (cnt <= AE_T);
  assign count        = cnt;

  // A pop frees the shared slot, so a write into a full FIFO is legal alongside a read
  assign rd_acc = rd_en && !empty;
  assign wr_acc = wr_en && (!full || rd_acc);

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_idx] <= din;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else begin
      case ({wr_acc, rd_acc})
        2'b10:   cnt <= cnt + PW'(1);
        2'b01:   cnt <= cnt - PW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Sticky errors; a new event in the clearing cycle keeps the flag set
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && !wr_acc) overflow <= 1'b1;
      else if (clr_err)     overflow <= 1'b0;
      if (rd_en && empty)   underflow <= 1'b1;
      else if (clr_err)     underflow <= 1'b0;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign dout = mem[rd_idx];
    end else begin : g_reg
      logic [DSIZE-1:0] dout_q;
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)       dout_q <= '0;
        else if (rd_acc) dout_q <= mem[rd_idx];
      end
      assign dout = dout_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Directed bench for sync_fifo_flex: registered-read instance plus an FWFT instance.
module tb_sync_fifo_flex;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn;
  logic       wr_en, rd_en, clr_err;
  logic [7:0] din, dout;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;

  logic       f_wr_en, f_rd_en, f_clr_err;
  logic [7:0] f_din, f_dout;
  logic       f_full, f_empty, f_almost_full, f_almost_empty, f_overflow, f_underflow;
  logic [4:0] f_count;

  int checks = 0;
  int failures = 0;

  sync_fifo_flex #(.DSIZE(8), .ASIZE(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(0)) dut (
    .clk(clk), .rstn(rstn), .wr_en(wr_en), .din(din), .rd_en(rd_en), .dout(dout),
    .clr_err(clr_err), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .overflow(overflow), .underflow(underflow)
  );

  sync_fifo_flex #(.DSIZE(8), .ASIZE(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(1)) dut_fwft (
    .clk(clk), .rstn(rstn), .wr_en(f_wr_en), .din(f_din), .rd_en(f_rd_en), .dout(f_dout),
    .clr_err(f_clr_err), .full(f_full), .empty(f_empty), .almost_full(f_almost_full),
    .almost_empty(f_almost_empty), .count(f_count), .overflow(f_overflow),
    .underflow(f_underflow)
  );

  task automatic cyc(input logic we, input logic [7:0] d, input logic re, input logic ce);
    wr_en = we; din = d; rd_en = re; clr_err = ce;
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
  endtask

  task automatic f_cyc(input logic we, input logic [7:0] d, input logic re);
    f_wr_en = we; f_din = d; f_rd_en = re;
    @(posedge clk); #1;
    f_wr_en = 1'b0; f_rd_en = 1'b0;
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    wr_en = 0; rd_en = 0; clr_err = 0; din = '0;
    f_wr_en = 0; f_rd_en = 0; f_clr_err = 0; f_din = '0;
    #1;
    checks++;
    if ({count, empty, full, almost_full, almost_empty, overflow, underflow} !== {5'd0, 6'b100100}) begin
      failures++;
      $display("FAIL reset_flags got cnt=%0d e=%b f=%b af=%b ae=%b ov=%b uf=%b exp cnt=0 e=1 f=0 af=0 ae=1 ov=0 uf=0",
               count, empty, full, almost_full, almost_empty, overflow, underflow);
    end
    checks++;
    if (dout !== 8'h00) begin failures++; $display("FAIL reset_dout got=%h exp=00", dout); end
    repeat (2) @(posedge clk);
    @(negedge clk) rstn = 1'b1;
  endtask

  task automatic test_fill;
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 8'(i), 1'b0, 1'b0);
      checks++;
      if (count !== 5'(i + 1)) begin
        failures++; $display("FAIL fill_count i=%0d got=%0d exp=%0d", i, count, i + 1);
      end
      checks++;
      if (almost_empty !== (i + 1 <= 2)) begin
        failures++; $display("FAIL fill_ae i=%0d got=%b exp=%b", i, almost_empty, (i + 1 <= 2));
      end
      checks++;
      if (almost_full !== (i + 1 >= 14)) begin
        failures++; $display("FAIL fill_af i=%0d got=%b exp=%b", i, almost_full, (i + 1 >= 14));
      end
      checks++;
      if (full !== (i + 1 == 16)) begin
        failures++; $display("FAIL fill_full i=%0d got=%b exp=%b", i, full, (i + 1 == 16));
      end
    end
    cyc(1'b1, 8'hEE, 1'b0, 1'b0);
    checks++;
    if (overflow !== 1'b1 || count !== 5'd16) begin
      failures++; $display("FAIL overflow_17th got ov=%b cnt=%0d exp ov=1 cnt=16", overflow, count);
    end
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    checks++;
    if (overflow !== 1'b0) begin failures++; $display("FAIL clr_overflow got=%b exp=0", overflow); end
  endtask

  task automatic test_drain;
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      checks++;
      if (dout !== 8'(i)) begin failures++; $display("FAIL drain_data i=%0d got=%h exp=%h", i, dout, 8'(i)); end
      checks++;
      if (count !== 5'(15 - i) || empty !== (i == 15)) begin
        failures++; $display("FAIL drain_state i=%0d got cnt=%0d e=%b exp cnt=%0d e=%b", i, count, empty, 15 - i, (i == 15));
      end
    end
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (underflow !== 1'b1 || dout !== 8'h0F || count !== 5'd0) begin
      failures++; $display("FAIL underflow_17th got uf=%b dout=%h cnt=%0d exp uf=1 dout=0f cnt=0", underflow, dout, count);
    end
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    checks++;
    if (underflow !== 1'b0) begin failures++; $display("FAIL clr_underflow got=%b exp=0", underflow); end
  endtask

  task automatic test_full_rw;
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    cyc(1'b1, 8'h30, 1'b1, 1'b0);
    checks++;
    if (count !== 5'd16 || full !== 1'b1 || overflow !== 1'b0 || dout !== 8'h20) begin
      failures++; $display("FAIL full_rw got cnt=%0d f=%b ov=%b dout=%h exp cnt=16 f=1 ov=0 dout=20", count, full, overflow, dout);
    end
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      checks++;
      if (dout !== 8'(8'h21 + i)) begin
        failures++; $display("FAIL full_rw_drain i=%0d got=%h exp=%h", i, dout, 8'(8'h21 + i));
      end
    end
  endtask

  task automatic test_empty_rw;
    cyc(1'b1, 8'h44, 1'b1, 1'b0);
    checks++;
    if (count !== 5'd1 || underflow !== 1'b1 || empty !== 1'b0 || dout !== 8'h30) begin
      failures++; $display("FAIL empty_rw got cnt=%0d uf=%b e=%b dout=%h exp cnt=1 uf=1 e=0 dout=30", count, underflow, empty, dout);
    end
    cyc(1'b0, 8'h00, 1'b1, 1'b1);
    checks++;
    if (dout !== 8'h44 || empty !== 1'b1 || underflow !== 1'b0) begin
      failures++; $display("FAIL empty_rw_read got dout=%h e=%b uf=%b exp dout=44 e=1 uf=0", dout, empty, underflow);
    end
  endtask

  task automatic test_fwft;
    f_cyc(1'b1, 8'hA5, 1'b0);
    checks++;
    if (f_empty !== 1'b0 || f_dout !== 8'hA5 || f_count !== 5'd1) begin
      failures++; $display("FAIL fwft_write got e=%b dout=%h cnt=%0d exp e=0 dout=a5 cnt=1", f_empty, f_dout, f_count);
    end
    f_cyc(1'b0, 8'h00, 1'b1);
    checks++;
    if (f_empty !== 1'b1 || f_count !== 5'd0) begin
      failures++; $display("FAIL fwft_pop got e=%b cnt=%0d exp e=1 cnt=0", f_empty, f_count);
    end
    f_cyc(1'b1, 8'h11, 1'b0);
    f_cyc(1'b1, 8'h22, 1'b0);
    checks++;
    if (f_dout !== 8'h11) begin failures++; $display("FAIL fwft_head got=%h exp=11", f_dout); end
    f_cyc(1'b0, 8'h00, 1'b1);
    checks++;
    if (f_dout !== 8'h22 || f_count !== 5'd1) begin
      failures++; $display("FAIL fwft_next got dout=%h cnt=%0d exp dout=22 cnt=1", f_dout, f_count);
    end
    f_cyc(1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_wrap;
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      cyc(1'b1, 8'(8'h55 + i), 1'b1, 1'b0);
      checks++;
      if (dout !== 8'(8'h50 + i) || count !== 5'd5) begin
        failures++; $display("FAIL wrap i=%0d got dout=%h cnt=%0d exp dout=%h cnt=5", i, dout, count, 8'(8'h50 + i));
      end
    end
    checks++;
    if (overflow !== 1'b0 || underflow !== 1'b0) begin
      failures++; $display("FAIL wrap_errs got ov=%b uf=%b exp 0 0", overflow, underflow);
    end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'h90 + i), 1'b0, 1'b0);
    checks++;
    if (count !== 5'd9) begin failures++; $display("FAIL mid_occupancy got=%0d exp=9", count); end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (count !== 5'd0 || empty !== 1'b1 || almost_empty !== 1'b1 || full !== 1'b0) begin
      failures++; $display("FAIL mid_reset got cnt=%0d e=%b ae=%b f=%b exp cnt=0 e=1 ae=1 f=0", count, empty, almost_empty, full);
    end
    @(negedge clk) rstn = 1'b1;
  endtask

  task automatic test_clr_set_wins;
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
    cyc(1'b1, 8'hFF, 1'b0, 1'b1);
    checks++;
    if (overflow !== 1'b1 || count !== 5'd16) begin
      failures++; $display("FAIL clr_set_wins got ov=%b cnt=%0d exp ov=1 cnt=16", overflow, count);
    end
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    checks++;
    if (overflow !== 1'b0) begin failures++; $display("FAIL clr_after got=%b exp=0", overflow); end
  endtask

  initial begin
    test_reset;
    test_fill;
    test_drain;
    test_full_rw;
    test_empty_rw;
    test_fwft;
    test_wrap;
    test_reset_mid;
    test_clr_set_wins;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
